arbiter_puf_ctrl: RTL and testbench
===================================

# arbiter_puf_ctrl

Parametrised challenge/response evaluation engine for an external N-stage arbiter-PUF delay chain. It drives the chain's challenge vector and launch edge, clears and samples the arbiter latch, and repeats each evaluation `N_EVAL` times to form a majority-voted bit. It produces a `RESP_BITS`-wide response from one base challenge by rotating it per bit, and reports how many bits were not unanimous. It sits between the AXI register wrapper and the dont_touch switch-stage chain plus arbiter latch.

## Interface
- `N_STAGES`, 64: challenge width, one bit per switch stage of the chain.
- `RESP_BITS`, 8: response bits per request; 1..`N_STAGES`.
- `N_EVAL`, 7: evaluations per response bit; odd, ≥1.
- `SETTLE_CYC`, 4: cycles `launch` is held high, and cycles it is held low afterwards; ≥1.
- `s00_axi_aclk`  in  1  sole clock; all logic on the rising edge.
- `s00_axi_aresetn`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; accepted only in IDLE.
- `challenge_in`  in  `N_STAGES`  base challenge; captured on accept.
- `busy`  out  1  high from the cycle after accept through the DONE cycle.
- `done`  out  1  one-cycle pulse; `response`/`unstable` valid from this cycle.
- `response`  out  `RESP_BITS`  voted response; bit k is in `response[k]`.
- `unstable`  out  clog2(`RESP_BITS`+1)  count of bits whose `N_EVAL` samples were not unanimous.
- `chal_out`  out  `N_STAGES`  challenge to the chain's select inputs.
- `launch`  out  1  race-start edge into both chain inputs.
- `arb_clr`  out  1  clears the arbiter latch.
- `arb_bit`  in  1  arbiter output, already synchronised to `s00_axi_aclk` by the integrator.

## Operation
- FSM states: IDLE, SETUP, SETTLE, RELAX, VOTE, DONE.
- IDLE → SETUP when `start`=1. Latch `challenge_in`. Clear the bit index k, the eval counter and the ones counter. Clear the `unstable` accumulator.
- SETUP, 1 cycle: `arb_clr`=1, `launch`=0. `chal_out` = base challenge rotated left by k, i.e. `chal_out[i]` = base[(i−k) mod `N_STAGES`]. `chal_out` stays stable through SETTLE and RELAX.
- SETTLE, `SETTLE_CYC` cycles: `launch`=1. On the clock edge ending the last SETTLE cycle, sample `arb_bit` and add it to the ones counter.
- RELAX, `SETTLE_CYC` cycles: `launch`=0. Then:
  - if fewer than `N_EVAL` evaluations have been made for this bit → SETUP;
  - otherwise → VOTE.
- VOTE, 1 cycle:
  - bit k = (ones ≥ (`N_EVAL`+1)/2);
  - if ones ≠ 0 and ones ≠ `N_EVAL`, increment `unstable`;
  - reset the ones and eval counters, then increment k;
  - k = `RESP_BITS` → DONE, else → SETUP.
- DONE, 1 cycle: `done`=1, `busy`=1. The staged response and count are transferred to `response`/`unstable`, visible in this same cycle. Then → IDLE.
- `response`/`unstable` hold their value until the next DONE. They do not change during a run.
- `start` is ignored outside IDLE, including in the DONE cycle. A continuously high `start` re-accepts in the first IDLE cycle after DONE.
- `chal_out` holds its last value in IDLE.
- Reset (`s00_axi_aresetn`=0 at an edge), at any time including mid-run:
  - all outputs go to 0: `busy`, `done`, `launch`, `arb_clr`, `chal_out`, `response`, `unstable`;
  - FSM → IDLE and all counters are cleared;
  - no `done` is issued for the aborted run.

## Timing
- Per evaluation: 1 + 2·`SETTLE_CYC` cycles. Per bit: `N_EVAL`·(1+2·`SETTLE_CYC`) + 1 cycles.
- `start` accepted at edge t ⇒ SETUP is cycle t+1. `done` is high in cycle t+1+`RESP_BITS`·(`N_EVAL`·(1+2·`SETTLE_CYC`)+1).
- With defaults this is t+513. The next start can be accepted at t+514 at the earliest.
- `launch` has a rising edge exactly `N_EVAL`·`RESP_BITS` times per run. Each rising edge is preceded by exactly one `arb_clr` cycle.
- `arb_bit` is sampled `SETTLE_CYC`−1 cycles after the `launch` rising cycle, at the end of the last SETTLE cycle.

## Test plan
- Reset: hold `s00_axi_aresetn`=0 for 3 cycles, then release → all outputs 0 and `busy`=0. `start`=0 thereafter → outputs remain 0.
- Defaults, `arb_bit` tied 1, `challenge_in`=64'h1, `start` pulsed at t:
  - `done` only at t+513, with `response`=8'hFF and `unstable`=0;
  - `chal_out` in bit 3's SETUP = 64'h8;
  - 56 launch rising edges in total.
- Model `arb_bit` = `chal_out[0]` (registered into the sample cycle), `challenge_in`=64'h8000_0000_0000_0001 → `response`=8'h03, `unstable`=0.
- Noisy model, base `arb_bit`=0:
  - bit 2 returns 1 on 4 of its 7 samples;
  - bit 5 returns 1 on 3 of its 7 samples;
  - required: `response`=8'h04, `unstable`=2.
- Protocol: pulse `start` at t+10, t+200 and in the DONE cycle of a run, each with a different `challenge_in` → all ignored; the response reflects the challenge captured at t. `start` held high → second `done` exactly 514 cycles after the first.
- Reset mid-run: drop `s00_axi_aresetn` at cycle t+100 for 1 cycle → from t+101, `busy`, `launch` and `response` are 0 and no `done` is issued. A restart produces a correct 513-cycle run.

Source files
------------

// File: rtl/arbiter_puf_ctrl.sv
// Challenge/response sequencer for an external arbiter-PUF delay chain.
// Every response bit is the majority of N_EVAL launches, each on a per-bit rotated challenge.
module arbiter_puf_ctrl #(
    parameter int N_STAGES   = 64,
    parameter int RESP_BITS  = 8,
    parameter int N_EVAL     = 7,
    parameter int SETTLE_CYC = 4,
    localparam int UW        = $clog2(RESP_BITS + 1)
) (
    input  logic                 s00_axi_aclk,
    input  logic                 s00_axi_aresetn,
    input  logic                 start,
    input  logic [N_STAGES-1:0]  challenge_in,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic [UW-1:0]        unstable,
    output logic [N_STAGES-1:0]  chal_out,
    output logic                 launch,
    output logic                 arb_clr,
    input  logic                 arb_bit
);
    // state  | meaning
    // IDLE   | waiting for start     SETUP | arb_clr pulse, challenge applied
    // SETTLE | launch high, sample   RELAX | launch low, chain recovers
    // VOTE   | majority of one bit   DONE  | results published, done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SETTLE, S_RELAX, S_VOTE, S_DONE
    } state_t;

    localparam int KW  = $clog2(RESP_BITS + 1);
    localparam int EW  = $clog2(N_EVAL + 1);
    localparam int TW  = $clog2(SETTLE_CYC + 1);
    localparam int MAJ = (N_EVAL + 1) / 2;

    state_t               r_state;
    logic [N_STAGES-1:0]  r_chal;
    logic [KW-1:0]        r_k;
    logic [EW-1:0]        r_eval;
    logic [EW-1:0]        r_ones;
    logic [TW-1:0]        r_timer;
    logic [RESP_BITS-1:0] r_resp_stage;
    logic [UW-1:0]        r_unst_stage;
    logic [RESP_BITS-1:0] r_response;
    logic [UW-1:0]        r_unstable;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_launch;
    logic                 r_arb_clr;

    logic                 w_vote_bit;
    logic                 w_split;
    logic [RESP_BITS-1:0] w_resp_next;
    logic [UW-1:0]        w_unst_next;
    logic [KW-1:0]        w_k_next;
    logic [N_STAGES-1:0]  w_chal_rot;

    always_comb begin
        w_vote_bit  = (r_ones >= EW'(MAJ));
        w_split     = (r_ones != '0) && (r_ones != EW'(N_EVAL));
        w_resp_next = r_resp_stage | (RESP_BITS'(w_vote_bit) << r_k);
        w_unst_next = r_unst_stage + UW'(w_split);
        w_k_next    = r_k + 1'b1;
        // Rotating the working copy by one per bit equals rotating the base by k.
        w_chal_rot  = (r_chal << 1) | (r_chal >> (N_STAGES - 1));
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_state      <= S_IDLE;
            r_chal       <= '0;
            r_k          <= '0;
            r_eval       <= '0;
            r_ones       <= '0;
            r_timer      <= '0;
            r_resp_stage <= '0;
            r_unst_stage <= '0;
            r_response   <= '0;
            r_unstable   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_launch     <= 1'b0;
            r_arb_clr    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_chal       <= challenge_in;
                        r_k          <= '0;
                        r_eval       <= '0;
                        r_ones       <= '0;
                        r_resp_stage <= '0;
                        r_unst_stage <= '0;
                        r_busy       <= 1'b1;
                        r_arb_clr    <= 1'b1;
                        r_state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_arb_clr <= 1'b0;
                    r_launch  <= 1'b1;
                    r_timer   <= TW'(SETTLE_CYC - 1);
                    r_state   <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_timer == '0) begin
                        r_ones   <= r_ones + EW'(arb_bit);
                        r_eval   <= r_eval + 1'b1;
                        r_launch <= 1'b0;
                        r_timer  <= TW'(SETTLE_CYC - 1);
                        r_state  <= S_RELAX;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_RELAX: begin
                    if (r_timer == '0) begin
                        if (r_eval < EW'(N_EVAL)) begin
                            r_arb_clr <= 1'b1;
                            r_state   <= S_SETUP;
                        end else begin
                            r_state <= S_VOTE;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_VOTE: begin
                    r_resp_stage <= w_resp_next;
                    r_unst_stage <= w_unst_next;
                    r_ones       <= '0;
                    r_eval       <= '0;
                    r_k          <= w_k_next;
                    if (w_k_next == KW'(RESP_BITS)) begin
                        r_response <= w_resp_next;
                        r_unstable <= w_unst_next;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_chal    <= w_chal_rot;
                        r_arb_clr <= 1'b1;
                        r_state   <= S_SETUP;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign response = r_response;
    assign unstable = r_unstable;
    assign chal_out = r_chal;
    assign launch   = r_launch;
    assign arb_clr  = r_arb_clr;

endmodule

// File: tb/tb_arbiter_puf_ctrl.sv
// Scoreboard bench for arbiter_puf_ctrl: driver queues expected results, a monitor
// checks them on every done pulse alongside launch/arb_clr sequencing.
module tb_arbiter_puf_ctrl;
    localparam int NE  = 7;
    localparam int RB  = 8;
    localparam int RUN = 512;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        arb_bit = 1'b0;
    logic [63:0] challenge_in = '0;
    logic        busy, done, launch, arb_clr;
    logic [7:0]  response;
    logic [3:0]  unstable;
    logic [63:0] chal_out;

    arbiter_puf_ctrl dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rstn),
        .start           (start),
        .challenge_in    (challenge_in),
        .busy            (busy),
        .done            (done),
        .response        (response),
        .unstable        (unstable),
        .chal_out        (chal_out),
        .launch          (launch),
        .arb_clr         (arb_clr),
        .arb_bit         (arb_bit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0]  resp;
        logic [3:0]  unst;
        logic [63:0] chal3;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Chain model: 0 = constant, 1 = follows chal_out[0], 2 = scripted noise per evaluation.
    int   mode = 0;
    logic const_bit = 1'b1;
    int   ev_cnt = 0;
    int   ev_idx, ev_bit, ev_smp;
    always @(negedge clk) begin
        if (done || !rstn) ev_cnt = 0;
        else if (arb_clr) ev_cnt = ev_cnt + 1;
        ev_idx = ev_cnt - 1;
        ev_bit = ev_idx / NE;
        ev_smp = ev_idx % NE;
        case (mode)
            0:       arb_bit = const_bit;
            1:       arb_bit = chal_out[0];
            default: arb_bit = ((ev_bit == 2) && (ev_smp < 4)) || ((ev_bit == 5) && (ev_smp < 3));
        endcase
    end

    int   launches = 0;
    int   clrs = 0;
    logic prev_launch = 1'b0;
    logic prev_clr = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            launches    = 0;
            clrs        = 0;
            prev_launch = 1'b0;
            prev_clr    = 1'b0;
        end else begin
            if (launch && !prev_launch) begin
                launches++;
                check("clr_before_launch", 64'(prev_clr), 64'd1);
            end
            if (arb_clr) begin
                if (clrs == 3 * NE && sb.size() > 0)
                    check("chal_bit3_setup", chal_out, sb[0].chal3);
                clrs++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    cur = sb.pop_front();
                    check("response", 64'(response), 64'(cur.resp));
                    check("unstable", 64'(unstable), 64'(cur.unst));
                    check("done_cycle", 64'(cyc), 64'(cur.cyc));
                    check("busy_at_done", 64'(busy), 64'd1);
                    check("launch_edges", 64'(launches), 64'(NE * RB));
                end
                launches = 0;
                clrs     = 0;
            end
            prev_launch = launch;
            prev_clr    = arb_clr;
        end
    end

    task automatic issue(input logic [63:0] ch, input logic [7:0] r, input logic [3:0] u,
                         input logic [63:0] c3);
        exp_t e;
        @(negedge clk);
        challenge_in = ch;
        start        = 1'b1;
        e.resp  = r;
        e.unst  = u;
        e.chal3 = c3;
        e.cyc   = cyc + 1 + RUN;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL run_timeout: %0d results pending after %0d cycles", sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_busy"},     64'(busy),     64'd0);
        check({tag, "_done"},     64'(done),     64'd0);
        check({tag, "_launch"},   64'(launch),   64'd0);
        check({tag, "_arb_clr"},  64'(arb_clr),  64'd0);
        check({tag, "_chal_out"}, chal_out,      64'd0);
        check({tag, "_response"}, 64'(response), 64'd0);
        check({tag, "_unstable"}, 64'(unstable), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int a;
    exp_t e1, e2;
    initial begin
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk_zero("idle_after_reset");

        mode = 0; const_bit = 1'b1;
        issue(64'h1, 8'hFF, 4'd0, 64'h8);
        wait_empty(700);
        repeat (3) @(negedge clk);

        mode = 1;
        issue(64'h8000_0000_0000_0001, 8'h03, 4'd0, 64'hC);
        wait_empty(700);
        repeat (3) @(negedge clk);

        mode = 2;
        issue(64'h0, 8'h04, 4'd2, 64'h0);
        wait_empty(700);
        repeat (3) @(negedge clk);

        // Extra start pulses mid-run and in the DONE cycle must be ignored.
        mode = 1;
        issue(64'h5, 8'h01, 4'd0, 64'h28);
        a = cyc;
        while (cyc < a + 9) @(negedge clk);
        challenge_in = '1; start = 1'b1;
        @(negedge clk); start = 1'b0; challenge_in = 64'h3;
        while (cyc < a + 199) @(negedge clk);
        challenge_in = 64'hF0F0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (cyc < a + RUN) @(negedge clk);
        challenge_in = '1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (600) @(negedge clk);
        wait_empty(10);

        // Held start: back-to-back runs 514 cycles apart.
        mode = 1;
        @(negedge clk);
        challenge_in = 64'h8000_0000_0000_0001;
        start = 1'b1;
        a = cyc + 1;
        e1.resp = 8'h03; e1.unst = 4'd0; e1.chal3 = 64'hC; e1.cyc = a + RUN;
        e2 = e1;         e2.cyc = a + RUN + 514;
        sb.push_back(e1);
        sb.push_back(e2);
        while (cyc < a + 1000) @(negedge clk);
        start = 1'b0;
        wait_empty(300);
        repeat (3) @(negedge clk);

        // Reset in the middle of a run: no done, outputs cleared, clean restart.
        mode = 0; const_bit = 1'b1;
        issue(64'h1, 8'hFF, 4'd0, 64'h8);
        a = cyc;
        while (cyc < a + 99) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        sb.delete();
        check("midreset_busy",     64'(busy),     64'd0);
        check("midreset_launch",   64'(launch),   64'd0);
        check("midreset_response", 64'(response), 64'd0);
        check("midreset_done",     64'(done),     64'd0);
        repeat (600) @(negedge clk);
        check("midreset_still_idle", 64'(busy), 64'd0);
        issue(64'h1, 8'hFF, 4'd0, 64'h8);
        wait_empty(700);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
